// File: rtl/axi_lite_mem_master.sv
// AXI-lite initiator bridge: word-addressed valid/ready memory requests
// become single-outstanding AXI-lite transactions with in-order responses.

package axi_common;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
endpackage

interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn
);
    import axi_common::*;

    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid;
    logic                    b_ready;
    resp_t                   b_resp;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    resp_t                   r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb,
        output b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_addr, w_valid, w_data, w_strb,
        input  b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

module axi_lite_mem_master #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_WIDTH/8-1:0]   req_we,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    axi_lite_channel.master           master
);
    import axi_common::*;

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int AXI_AW = $bits(master.aw_addr);
    localparam int AXI_DW = $bits(master.w_data);

    if (AXI_DW != DATA_WIDTH) begin : g_dw_chk
        $fatal(1, "DATA_WIDTH differs from master data width");
    end
    if (MEM_ADDR_WIDTH + OFF > AXI_AW) begin : g_aw_chk
        $fatal(1, "word address does not fit master address width");
    end

    typedef enum logic [2:0] {
        IDLE, WRITE, WRESP, READ, RDATA, RESP
    } state_t;

    state_t state, state_n;

    logic [AXI_AW-1:0]     addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic                  aw_valid_q;
    logic                  w_valid_q;
    logic                  ar_valid_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;
    logic                  b_ready_c;
    logic                  r_ready_c;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, accept;
    logic aw_done_n, w_done_n;

    assign aw_hs     = aw_valid_q & master.aw_ready;
    assign w_hs      = w_valid_q & master.w_ready;
    assign ar_hs     = ar_valid_q & master.ar_ready;
    assign b_hs      = b_ready_c & master.b_valid;
    assign r_hs      = r_ready_c & master.r_valid;
    assign accept    = req_valid & req_ready;
    assign aw_done_n = aw_done | aw_hs;
    assign w_done_n  = w_done | w_hs;

    assign master.aw_valid = aw_valid_q;
    assign master.aw_addr  = addr_q;
    assign master.w_valid  = w_valid_q;
    assign master.w_data   = wdata_q;
    assign master.w_strb   = strb_q;
    assign master.ar_valid = ar_valid_q;
    assign master.ar_addr  = addr_q;
    assign master.b_ready  = b_ready_c;
    assign master.r_ready  = r_ready_c;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and per-state handshake decodes
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        b_ready_c = 1'b0;
        r_ready_c = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = (|req_we) ? WRITE : READ;
            end
            WRITE: begin
                if (aw_done_n && w_done_n) state_n = WRESP;
            end
            WRESP: begin
                b_ready_c = 1'b1;
                if (master.b_valid) state_n = RESP;
            end
            READ: begin
                if (ar_hs) state_n = RDATA;
            end
            RDATA: begin
                r_ready_c = 1'b1;
                if (master.r_valid) state_n = RESP;
            end
            RESP: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request capture, AXI valids and response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= AXI_AW'(req_addr) << OFF;
                wdata_q <= req_wdata;
                strb_q  <= req_we;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (|req_we) begin
                    aw_valid_q <= 1'b1;
                    w_valid_q  <= 1'b1;
                end else begin
                    ar_valid_q <= 1'b1;
                end
            end
            if (aw_hs) begin
                aw_valid_q <= 1'b0;
                aw_done    <= 1'b1;
            end
            if (w_hs) begin
                w_valid_q <= 1'b0;
                w_done    <= 1'b1;
            end
            if (ar_hs) ar_valid_q <= 1'b0;
            if (b_hs) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= '0;
                resp_err_q   <= (master.b_resp != RESP_OKAY);
            end
            if (r_hs) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= master.r_data;
                resp_err_q   <= (master.r_resp != RESP_OKAY);
            end
            if (state == RESP && resp_ready) resp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Bench for axi_lite_mem_master: table of requests against a scripted
// AXI-lite slave, scoreboard of responses, plus a mid-write reset sequence.

module tb_axi_lite_mem_master;
    import axi_common::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus (
        .clk(clk), .rstn(rstn)
    );

    axi_lite_mem_master #(.DATA_WIDTH(64), .MEM_ADDR_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .master(bus)
    );

    typedef struct {
        logic [7:0]  we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ad;
        int          wd;
        logic [1:0]  rsp;
        int          hold;
        bit          pre;
        logic [31:0] ea;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[9];
    vec_t vr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aw_beats = 0;
    int w_beats = 0;
    int ar_beats = 0;

    always @(posedge clk) begin
        cyc++;
        if (bus.aw_valid && bus.aw_ready) aw_beats++;
        if (bus.w_valid && bus.w_ready) w_beats++;
        if (bus.ar_valid && bus.ar_ready) ar_beats++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [7:0] we, input logic [15:0] addr,
        input logic [63:0] wdata, input logic [63:0] rdata,
        input int ad, input int wd, input logic [1:0] rsp,
        input int hold, input bit pre, input logic [31:0] ea,
        input logic err, input int lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.ad = ad; v.wd = wd; v.rsp = rsp; v.hold = hold; v.pre = pre;
        v.ea = ea; v.err = err; v.lat = lat;
        return v;
    endfunction

    function automatic logic ch_valid(input int which);
        case (which)
            0:       return bus.aw_valid;
            1:       return bus.w_valid;
            default: return bus.ar_valid;
        endcase
    endfunction

    function automatic logic [63:0] ch_data(input int which);
        case (which)
            0:       return 64'(bus.aw_addr);
            1:       return bus.w_data;
            default: return 64'(bus.ar_addr);
        endcase
    endfunction

    task automatic set_ready(input int which, input logic v);
        case (which)
            0:       bus.aw_ready = v;
            1:       bus.w_ready = v;
            default: bus.ar_ready = v;
        endcase
    endtask

    // Slave side of one AW, W or AR channel with d wait cycles
    task automatic chan(input int which, input int d,
                        input logic [63:0] ev, input logic [7:0] es);
        int t = 0;
        while (!ch_valid(which) && t < 20) begin
            step();
            t++;
        end
        if (!ch_valid(which)) begin
            chk($sformatf("chan%0d_timeout", which), 0, 1);
            return;
        end
        for (int k = 0; k < d; k++) begin
            chk($sformatf("chan%0d_payload_hold", which), ch_data(which), ev);
            chk("req_ready_busy", 64'(req_ready), 0);
            step();
            chk($sformatf("chan%0d_valid_hold", which), 64'(ch_valid(which)), 1);
        end
        chk($sformatf("chan%0d_payload", which), ch_data(which), ev);
        if (which == 1) chk("w_strb", 64'(bus.w_strb), 64'(es));
        set_ready(which, 1'b1);
        step();
        set_ready(which, 1'b0);
        chk($sformatf("chan%0d_valid_drop", which), 64'(ch_valid(which)), 0);
    endtask

    task automatic run_txn(input vec_t v, input vec_t nx);
        int t;
        int acc;
        logic [63:0] rd0;
        logic er0;
        exp_t e;
        bit wr;
        wr = |v.we;
        aw_beats = 0; w_beats = 0; ar_beats = 0;
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            step();
            t++;
        end
        chk("req_accept", 64'(req_ready), 1);
        acc = cyc;
        step();
        req_valid = 1'b0;
        e.rdata = wr ? 64'h0 : v.rdata;
        e.err = v.err;
        sbq.push_back(e);
        if (wr) begin
            fork
                chan(0, v.ad, 64'(v.ea), 8'h0);
                chan(1, v.wd, v.wdata, v.we);
            join
            bus.b_resp = v.rsp;
            bus.b_valid = 1'b1;
            t = 0;
            while (!bus.b_ready && t < 20) begin
                step();
                t++;
            end
            chk("b_ready", 64'(bus.b_ready), 1);
            if (bus.b_ready) step();
            bus.b_valid = 1'b0;
        end else begin
            chan(2, v.ad, 64'(v.ea), 8'h0);
            bus.r_resp = v.rsp;
            bus.r_data = v.rdata;
            bus.r_valid = 1'b1;
            t = 0;
            while (!bus.r_ready && t < 20) begin
                step();
                t++;
            end
            chk("r_ready", 64'(bus.r_ready), 1);
            if (bus.r_ready) step();
            bus.r_valid = 1'b0;
        end
        t = 0;
        while (!resp_valid && t < 20) begin
            step();
            t++;
        end
        chk("resp_valid", 64'(resp_valid), 1);
        if (v.lat >= 0) chk("latency", 64'(cyc - acc), 64'(v.lat));
        rd0 = resp_rdata;
        er0 = resp_err;
        for (int k = 0; k < v.hold; k++) begin
            if (v.pre) begin
                req_we = nx.we; req_addr = nx.addr; req_wdata = nx.wdata;
                req_valid = 1'b1;
            end
            step();
            chk("hold_valid", 64'(resp_valid), 1);
            chk("hold_rdata", resp_rdata, rd0);
            chk("hold_err", 64'(resp_err), 64'(er0));
            chk("hold_axi_idle",
                64'({bus.aw_valid, bus.w_valid, bus.ar_valid}), 0);
            chk("hold_req_ready", 64'(req_ready), 0);
        end
        if (sbq.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 64'(resp_err), 64'(e.err));
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("resp_drop", 64'(resp_valid), 0);
        chk("aw_beats", 64'(aw_beats), wr ? 64'd1 : 64'd0);
        chk("w_beats", 64'(w_beats), wr ? 64'd1 : 64'd0);
        chk("ar_beats", 64'(ar_beats), wr ? 64'd0 : 64'd1);
    endtask

    initial begin
        vecs[0] = mk(8'hFF, 16'h0010, 64'h0123_4567_89AB_CDEF, 64'h0,
                     0, 0, RESP_OKAY, 0, 0, 32'h80, 1'b0, 3);
        vecs[1] = mk(8'h00, 16'h0003, 64'h0, 64'hDEAD_BEEF_0000_0001,
                     4, 0, RESP_OKAY, 0, 0, 32'h18, 1'b0, -1);
        vecs[2] = mk(8'h0F, 16'h0021, 64'hA5A5_5A5A_F00D_CAFE, 64'h0,
                     3, 0, RESP_OKAY, 0, 0, 32'h108, 1'b0, -1);
        vecs[3] = mk(8'hF0, 16'h0022, 64'h1111_2222_3333_4444, 64'h0,
                     0, 3, RESP_OKAY, 0, 0, 32'h110, 1'b0, -1);
        vecs[4] = mk(8'h01, 16'h0005, 64'h55, 64'h0,
                     0, 0, RESP_SLVERR, 0, 0, 32'h28, 1'b1, 3);
        vecs[5] = mk(8'h00, 16'h0006, 64'h0, 64'hBAD0_BAD0_BAD0_BAD0,
                     0, 0, RESP_DECERR, 0, 0, 32'h30, 1'b1, 3);
        vecs[6] = mk(8'h00, 16'h0007, 64'h0, 64'h7777_6666_5555_4444,
                     1, 0, RESP_OKAY, 5, 1, 32'h38, 1'b0, -1);
        vecs[7] = mk(8'h80, 16'hFFFF, 64'hFEED_FACE_0BAD_BEEF, 64'h0,
                     2, 1, RESP_OKAY, 0, 0, 32'h7FFF8, 1'b0, -1);
        vecs[8] = mk(8'h00, 16'h0000, 64'h0, 64'hCAFE_F00D_0000_0008,
                     0, 0, RESP_OKAY, 0, 0, 32'h0, 1'b0, 3);
        vr = mk(8'h00, 16'h1234, 64'h0, 64'h0BAD_F00D_1234_5678,
                0, 0, RESP_OKAY, 0, 0, 32'h91A0, 1'b0, 3);

        req_valid = 1'b0; req_we = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
        bus.b_valid = 1'b0; bus.b_resp = RESP_OKAY;
        bus.r_valid = 1'b0; bus.r_resp = RESP_OKAY; bus.r_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 1);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", 64'(resp_err), 0);
        chk("rst_axi_valids",
            64'({bus.aw_valid, bus.w_valid, bus.ar_valid}), 0);
        chk("rst_axi_readies", 64'({bus.b_ready, bus.r_ready}), 0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_txn(vecs[i], vecs[(i + 1) % 9]);

        // Reset while AW is done and W is still waiting
        req_we = 8'hFF; req_addr = 16'h0001; req_wdata = 64'h1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        bus.aw_ready = 1'b1;
        step();
        bus.aw_ready = 1'b0;
        chk("mid_aw_dropped", 64'(bus.aw_valid), 0);
        chk("mid_w_pending", 64'(bus.w_valid), 1);
        chk("mid_req_ready", 64'(req_ready), 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_w_valid", 64'(bus.w_valid), 0);
        chk("arst_req_ready", 64'(req_ready), 1);
        chk("arst_b_ready", 64'(bus.b_ready), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sbq.delete();
        step();
        run_txn(vr, vr);

        chk("sb_empty", 64'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
